// File: rtl/control_sequencer_if.sv
// Control-unit bundle between the sequencer and the datapath: instruction and
// condition inputs toward the sequencer, strobes and ALU opcode back out.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        conOut;
    logic        stop;

    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, conIn;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
    logic [4:0]  opcode;
    logic        run;

    modport master (
        input  ir, conOut, stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, conIn,
        output Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
        output opcode, run
    );

    modport slave (
        output ir, conOut, stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, conIn,
        input  Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
        input  opcode, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch, ALU and conditional-branch micro-sequences
// with a halt state; strobes are registered from the next-state decode.
module control_sequencer (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    localparam int unsigned OP_W = 5;
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_ALU_HI = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(5'b10010);
    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(5'b11011);

    typedef enum logic [3:0] {
        RST, FETCH0, FETCH1, FETCH2, ALU3, ALU4, ALU5,
        BR3, BR4, BR5, BR6, HALT
    } state_t;

    typedef struct packed {
        logic            pc_out;
        logic            pc_in;
        logic            inc_pc;
        logic            mar_in;
        logic            mdr_in;
        logic            mdr_out;
        logic            ir_in;
        logic            read;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            r_in;
        logic            r_out;
        logic            c_out;
        logic            con_in;
        logic            y_in;
        logic            z_in;
        logic            zlow_out;
        logic            run;
        logic [OP_W-1:0] opcode;
    } ctrl_t;

    state_t          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [OP_W-1:0] ir_op;
    logic            unused_ir;

    assign ir_op     = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

    // State register; clear drops straight back to RST
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= RST;
        else        state_q <= state_d;
    end

    // Next-state; stop is only honoured at instruction boundaries
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST:    state_d = FETCH0;
            FETCH0: state_d = FETCH1;
            FETCH1: state_d = FETCH2;
            FETCH2: begin
                if (ir_op <= OP_ALU_HI)     state_d = ALU3;
                else if (ir_op == OP_BRANCH) state_d = BR3;
                else if (ir_op == OP_HALT)   state_d = HALT;
                else                         state_d = bus.stop ? HALT : FETCH0;
            end
            ALU3:   state_d = ALU4;
            ALU4:   state_d = ALU5;
            ALU5:   state_d = bus.stop ? HALT : FETCH0;
            BR3:    state_d = BR4;
            BR4:    state_d = BR5;
            BR5:    state_d = BR6;
            BR6:    state_d = bus.stop ? HALT : FETCH0;
            HALT:   state_d = HALT;
            default: state_d = RST;
        endcase
    end

    // Strobe decode of the state being entered, so the registers track state_q
    always_comb begin
        ctrl_d     = '0;
        ctrl_d.run = (state_d != RST) && (state_d != HALT);
        unique case (state_d)
            FETCH0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.z_in   = 1'b1;
                ctrl_d.opcode = OP_ADD;
            end
            FETCH1: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
            end
            FETCH2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            ALU3: begin
                ctrl_d.grb   = 1'b1;
                ctrl_d.r_out = 1'b1;
                ctrl_d.y_in  = 1'b1;
            end
            ALU4: begin
                ctrl_d.grc    = 1'b1;
                ctrl_d.r_out  = 1'b1;
                ctrl_d.z_in   = 1'b1;
                ctrl_d.opcode = ir_op;
            end
            ALU5: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.gra      = 1'b1;
                ctrl_d.r_in     = 1'b1;
            end
            BR3: begin
                ctrl_d.gra    = 1'b1;
                ctrl_d.r_out  = 1'b1;
                ctrl_d.con_in = 1'b1;
            end
            BR4: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.y_in   = 1'b1;
            end
            BR5: begin
                ctrl_d.c_out  = 1'b1;
                ctrl_d.z_in   = 1'b1;
                ctrl_d.opcode = OP_ADD;
            end
            BR6:     ctrl_d.zlow_out = 1'b1;
            default: ctrl_d.run      = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) ctrl_q <= '0;
        else        ctrl_q <= ctrl_d;
    end

    assign bus.PCout   = ctrl_q.pc_out;
    // Branch-taken load of PC follows the live condition flag during BR6
    assign bus.PCin    = ctrl_q.pc_in | ((state_q == BR6) & bus.conOut);
    assign bus.IncPC   = ctrl_q.inc_pc;
    assign bus.MARin   = ctrl_q.mar_in;
    assign bus.MDRin   = ctrl_q.mdr_in;
    assign bus.MDRout  = ctrl_q.mdr_out;
    assign bus.IRin    = ctrl_q.ir_in;
    assign bus.Read    = ctrl_q.read;
    assign bus.Gra     = ctrl_q.gra;
    assign bus.Grb     = ctrl_q.grb;
    assign bus.Grc     = ctrl_q.grc;
    assign bus.Rin     = ctrl_q.r_in;
    assign bus.Rout    = ctrl_q.r_out;
    assign bus.Cout    = ctrl_q.c_out;
    assign bus.conIn   = ctrl_q.con_in;
    assign bus.Yin     = ctrl_q.y_in;
    assign bus.Zin     = ctrl_q.z_in;
    assign bus.Zlowout = ctrl_q.zlow_out;
    assign bus.opcode  = ctrl_q.opcode;
    assign bus.run     = ctrl_q.run;

    // Strobes with no user in this instruction subset
    assign bus.BAout    = 1'b0;
    assign bus.Zhighout = 1'b0;
    assign bus.HIin     = 1'b0;
    assign bus.HIout    = 1'b0;
    assign bus.LOin     = 1'b0;
    assign bus.LOout    = 1'b0;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a microprogram-table model.
module tb_control_sequencer;
    localparam int unsigned N_CYCLES = 3000;

    localparam int B_PCOUT = 0,  B_PCIN = 1,  B_INCPC = 2,  B_MARIN = 3;
    localparam int B_MDRIN = 4,  B_MDROUT = 5, B_IRIN = 6,  B_READ = 7;
    localparam int B_GRA = 8,    B_GRB = 9,   B_GRC = 10,   B_RIN = 11;
    localparam int B_ROUT = 12,  B_COUT = 14, B_CONIN = 15;
    localparam int B_YIN = 16,   B_ZIN = 17,  B_ZLOW = 18;

    localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2;
    localparam int S_FETCH = 0, S_ALU = 1, S_BR = 2;

    logic clock;
    logic clear;
    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [23:0] uc_fetch [3];
    logic [23:0] uc_alu   [3];
    logic [23:0] uc_br    [4];

    int          m_mode, m_seq, m_step, halt_cnt;
    logic [4:0]  m_op;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] bm(input int b);
        return 24'(1) << b;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {2'b00, bus.run, bus.opcode,
                bus.LOout, bus.LOin, bus.HIout, bus.HIin, bus.Zhighout, bus.Zlowout,
                bus.Zin, bus.Yin, bus.conIn, bus.Cout, bus.BAout, bus.Rout, bus.Rin,
                bus.Grc, bus.Grb, bus.Gra, bus.Read, bus.IRin, bus.MDRout, bus.MDRin,
                bus.MARin, bus.IncPC, bus.PCin, bus.PCout};
    endfunction

    // Expected outputs: microprogram row for the current step, plus opcode/run/condition
    function automatic logic [31:0] expect_vec(input logic con);
        logic [23:0] s;
        logic [4:0]  oc;
        logic        r;
        s = '0; oc = '0; r = 1'b0;
        if (m_mode == M_RUN) begin
            r = 1'b1;
            case (m_seq)
                S_FETCH: begin s = uc_fetch[m_step]; if (m_step == 0) oc = 5'd3; end
                S_ALU:   begin s = uc_alu[m_step];   if (m_step == 1) oc = m_op; end
                default: begin
                    s = uc_br[m_step];
                    if (m_step == 2) oc = 5'd3;
                    if (m_step == 3 && con) s = s | bm(B_PCIN);
                end
            endcase
        end
        return {2'b00, r, oc, s};
    endfunction

    // One clock edge of the instruction-level model
    task automatic model_edge();
        logic [4:0] op;
        op = bus.ir[31:27];
        if (!clear) begin
            m_mode = M_RESET;
        end else if (m_mode == M_RESET) begin
            m_mode = M_RUN; m_seq = S_FETCH; m_step = 0;
        end else if (m_mode == M_RUN) begin
            if (m_seq == S_FETCH && m_step == 2) begin
                m_op = op; m_step = 0;
                if (op <= 5'd12)       m_seq = S_ALU;
                else if (op == 5'd18)  m_seq = S_BR;
                else if (op == 5'd27)  m_mode = M_HALT;
                else if (bus.stop)     m_mode = M_HALT;
                else                   m_seq = S_FETCH;
            end else if ((m_seq == S_ALU && m_step == 2) || (m_seq == S_BR && m_step == 3)) begin
                m_step = 0; m_seq = S_FETCH;
                if (bus.stop) m_mode = M_HALT;
            end else begin
                m_step++;
            end
        end
    endtask

    function automatic logic [4:0] pick_op();
        int r;
        logic [4:0] o;
        r = int'($urandom_range(0, 19));
        if (r < 11)       o = 5'($urandom_range(0, 12));
        else if (r < 16)  o = 5'd18;
        else if (r < 18) begin
            o = 5'($urandom_range(13, 31));
            while (o == 5'd18 || o == 5'd27) o = 5'($urandom_range(13, 31));
        end else          o = 5'd27;
        return o;
    endfunction

    logic [4:0] dir_op  [4];
    logic       dir_con [4];
    int         dir_idx;
    logic [8:0] drivers;

    initial begin
        uc_fetch[0] = bm(B_PCOUT) | bm(B_MARIN) | bm(B_INCPC) | bm(B_ZIN);
        uc_fetch[1] = bm(B_ZLOW) | bm(B_PCIN) | bm(B_READ) | bm(B_MDRIN);
        uc_fetch[2] = bm(B_MDROUT) | bm(B_IRIN);
        uc_alu[0]   = bm(B_GRB) | bm(B_ROUT) | bm(B_YIN);
        uc_alu[1]   = bm(B_GRC) | bm(B_ROUT) | bm(B_ZIN);
        uc_alu[2]   = bm(B_ZLOW) | bm(B_GRA) | bm(B_RIN);
        uc_br[0]    = bm(B_GRA) | bm(B_ROUT) | bm(B_CONIN);
        uc_br[1]    = bm(B_PCOUT) | bm(B_YIN);
        uc_br[2]    = bm(B_COUT) | bm(B_ZIN);
        uc_br[3]    = bm(B_ZLOW);

        dir_op[0] = 5'd3;  dir_con[0] = 1'b0;
        dir_op[1] = 5'd18; dir_con[1] = 1'b1;
        dir_op[2] = 5'd18; dir_con[2] = 1'b0;
        dir_op[3] = 5'd27; dir_con[3] = 1'b0;
        dir_idx = 0;

        m_mode = M_RESET; m_seq = S_FETCH; m_step = 0; m_op = '0; halt_cnt = 0;
        clear = 1'b0;
        bus.ir = '0; bus.conOut = 1'b0; bus.stop = 1'b0;
        #1;
        check_val("reset_outs", dut_vec(), expect_vec(bus.conOut));

        for (int c = 0; c < int'(N_CYCLES); c++) begin
            @(posedge clock);
            cyc = c;
            model_edge();
            halt_cnt = (m_mode == M_HALT) ? halt_cnt + 1 : 0;
            #2;
            if (!clear) begin
                clear = 1'b1;
            end else if (m_mode == M_HALT && halt_cnt >= 10 + int'($urandom_range(0, 3))) begin
                clear = 1'b0; m_mode = M_RESET;
            end else if (dir_idx >= 4 && $urandom_range(0, 99) < 2) begin
                clear = 1'b0; m_mode = M_RESET;
            end
            if (m_mode == M_RUN && m_seq == S_FETCH && m_step == 0) begin
                bus.ir = $urandom;
                if (dir_idx < 4) begin
                    bus.ir[31:27] = dir_op[dir_idx];
                    bus.conOut    = dir_con[dir_idx];
                    dir_idx++;
                end else begin
                    bus.ir[31:27] = pick_op();
                end
            end
            if (dir_idx >= 4 && !(dir_idx == 4 && m_mode != M_RESET && c < 40)) begin
                bus.conOut = 1'($urandom_range(0, 1));
                bus.stop   = ($urandom_range(0, 99) < 6);
            end
            @(negedge clock);
            check_val("outs", dut_vec(), expect_vec(bus.conOut));
            drivers = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Rout,
                       bus.Cout, bus.BAout, bus.HIout, bus.LOout};
            check_val("bus_one_driver", 32'($countones(drivers) <= 1), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
